// File: rtl/sha256_duct_if.sv
// Block-source / monitor side bundle for sha256_duct: the message block, its
// last-block flag, and the registered request and match outputs.
interface sha256_duct_if;
  logic [511:0] block_n;
  logic         readout;
  logic         ask;
  logic         result;

  modport master (output block_n, output readout, input ask, input result);
  modport slave  (input block_n, input readout, output ask, output result);
endinterface

// File: rtl/sha256_duct.sv
// Iterative SHA-256 engine: one round per clock, chains pre-padded blocks and
// compares the final chaining value against an expected digest on the data bus.
module sha256_duct (
  input  logic         inclk,
  input  logic         reset,
  sha256_duct_if.slave bus
);

  localparam logic [1:0] LOAD  = 2'd0;
  localparam logic [1:0] ROUND = 2'd1;
  localparam logic [1:0] ASK   = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] iv_word(input logic [2:0] idx);
    case (idx)
      3'd0:    iv_word = 32'h6a09e667;
      3'd1:    iv_word = 32'hbb67ae85;
      3'd2:    iv_word = 32'h3c6ef372;
      3'd3:    iv_word = 32'ha54ff53a;
      3'd4:    iv_word = 32'h510e527f;
      3'd5:    iv_word = 32'h9b05688c;
      3'd6:    iv_word = 32'h1f83d9ab;
      3'd7:    iv_word = 32'h5be0cd19;
      default: iv_word = 32'h00000000;
    endcase
  endfunction

  function automatic logic [31:0] k_rom(input logic [5:0] idx);
    case (idx)
      6'd0:  k_rom = 32'h428a2f98;  6'd1:  k_rom = 32'h71374491;
      6'd2:  k_rom = 32'hb5c0fbcf;  6'd3:  k_rom = 32'he9b5dba5;
      6'd4:  k_rom = 32'h3956c25b;  6'd5:  k_rom = 32'h59f111f1;
      6'd6:  k_rom = 32'h923f82a4;  6'd7:  k_rom = 32'hab1c5ed5;
      6'd8:  k_rom = 32'hd807aa98;  6'd9:  k_rom = 32'h12835b01;
      6'd10: k_rom = 32'h243185be;  6'd11: k_rom = 32'h550c7dc3;
      6'd12: k_rom = 32'h72be5d74;  6'd13: k_rom = 32'h80deb1fe;
      6'd14: k_rom = 32'h9bdc06a7;  6'd15: k_rom = 32'hc19bf174;
      6'd16: k_rom = 32'he49b69c1;  6'd17: k_rom = 32'hefbe4786;
      6'd18: k_rom = 32'h0fc19dc6;  6'd19: k_rom = 32'h240ca1cc;
      6'd20: k_rom = 32'h2de92c6f;  6'd21: k_rom = 32'h4a7484aa;
      6'd22: k_rom = 32'h5cb0a9dc;  6'd23: k_rom = 32'h76f988da;
      6'd24: k_rom = 32'h983e5152;  6'd25: k_rom = 32'ha831c66d;
      6'd26: k_rom = 32'hb00327c8;  6'd27: k_rom = 32'hbf597fc7;
      6'd28: k_rom = 32'hc6e00bf3;  6'd29: k_rom = 32'hd5a79147;
      6'd30: k_rom = 32'h06ca6351;  6'd31: k_rom = 32'h14292967;
      6'd32: k_rom = 32'h27b70a85;  6'd33: k_rom = 32'h2e1b2138;
      6'd34: k_rom = 32'h4d2c6dfc;  6'd35: k_rom = 32'h53380d13;
      6'd36: k_rom = 32'h650a7354;  6'd37: k_rom = 32'h766a0abb;
      6'd38: k_rom = 32'h81c2c92e;  6'd39: k_rom = 32'h92722c85;
      6'd40: k_rom = 32'ha2bfe8a1;  6'd41: k_rom = 32'ha81a664b;
      6'd42: k_rom = 32'hc24b8b70;  6'd43: k_rom = 32'hc76c51a3;
      6'd44: k_rom = 32'hd192e819;  6'd45: k_rom = 32'hd6990624;
      6'd46: k_rom = 32'hf40e3585;  6'd47: k_rom = 32'h106aa070;
      6'd48: k_rom = 32'h19a4c116;  6'd49: k_rom = 32'h1e376c08;
      6'd50: k_rom = 32'h2748774c;  6'd51: k_rom = 32'h34b0bcb5;
      6'd52: k_rom = 32'h391c0cb3;  6'd53: k_rom = 32'h4ed8aa4a;
      6'd54: k_rom = 32'h5b9cca4f;  6'd55: k_rom = 32'h682e6ff3;
      6'd56: k_rom = 32'h748f82ee;  6'd57: k_rom = 32'h78a5636f;
      6'd58: k_rom = 32'h84c87814;  6'd59: k_rom = 32'h8cc70208;
      6'd60: k_rom = 32'h90befffa;  6'd61: k_rom = 32'ha4506ceb;
      6'd62: k_rom = 32'hbef9a3f7;  6'd63: k_rom = 32'hc67178f2;
      default: k_rom = 32'h00000000;
    endcase
  endfunction

  logic [1:0]  state;
  logic [5:0]  t;
  logic        last;
  logic        ask_flag;
  logic        result_flag;
  logic [31:0] hash [8];
  logic [31:0] w [16];
  logic [31:0] a, b, c, d, e, f, g, h;

  logic [31:0] t1, t2, new_a, new_e, w_next;
  logic        digest_match;
  logic        capture;

  assign bus.ask    = ask_flag;
  assign bus.result = result_flag;

  // Round datapath; w[0] is always W[t], w_next becomes W[t+16].
  always_comb begin
    t1     = h + big_sigma1(e) + ((e & f) ^ (~e & g)) + k_rom(t) + w[0];
    t2     = big_sigma0(a) + ((a & b) ^ (a & c) ^ (b & c));
    new_a  = t1 + t2;
    new_e  = d + t1;
    w_next = small_sigma1(w[14]) + w[9] + small_sigma0(w[1]) + w[0];
    digest_match = (bus.block_n[255:0] ==
                    {hash[7], hash[6], hash[5], hash[4], hash[3], hash[2], hash[1], hash[0]});
    capture = 1'b0;
    if (state == LOAD) begin
      capture = 1'b1;
    end else if (state == ASK) begin
      capture = ~last;
    end else begin
      capture = 1'b0;
    end
  end

  // Control FSM, schedule window, working variables and chaining value.
  always_ff @(posedge inclk or posedge reset) begin
    if (reset) begin
      state       <= LOAD;
      t           <= 6'd0;
      last        <= 1'b0;
      ask_flag    <= 1'b0;
      result_flag <= 1'b0;
      for (int i = 0; i < 8; i++) hash[i] <= iv_word(3'(i));
      for (int i = 0; i < 16; i++) w[i] <= 32'h00000000;
      {a, b, c, d, e, f, g, h} <= 256'd0;
    end else begin
      case (state)
        LOAD: begin
          state <= ROUND;
        end
        ROUND: begin
          {a, b, c, d, e, f, g, h} <= {new_a, a, b, c, new_e, e, f, g};
          for (int i = 0; i < 15; i++) w[i] <= w[i + 1];
          w[15] <= w_next;
          t     <= t + 6'd1;
          if (t == 6'd63) begin
            hash[0]  <= hash[0] + new_a;
            hash[1]  <= hash[1] + a;
            hash[2]  <= hash[2] + b;
            hash[3]  <= hash[3] + c;
            hash[4]  <= hash[4] + new_e;
            hash[5]  <= hash[5] + e;
            hash[6]  <= hash[6] + f;
            hash[7]  <= hash[7] + g;
            ask_flag <= 1'b1;
            state    <= ASK;
          end else begin
            state <= ROUND;
          end
        end
        ASK: begin
          ask_flag <= 1'b0;
          if (last) begin
            result_flag <= digest_match;
            state       <= DONE;
          end else begin
            state <= ROUND;
          end
        end
        DONE: begin
          state <= DONE;
        end
        default: begin
          state <= LOAD;
        end
      endcase
      // Capture happens only in LOAD/ASK, so it never collides with round updates.
      if (capture) begin
        for (int i = 0; i < 16; i++) w[i] <= bus.block_n[511 - 32*i -: 32];
        last <= bus.readout;
        t    <= 6'd0;
        {a, b, c, d, e, f, g, h} <=
          {hash[0], hash[1], hash[2], hash[3], hash[4], hash[5], hash[6], hash[7]};
      end
    end
  end

endmodule

// File: tb/tb_sha256_duct.sv
// Scoreboard bench for sha256_duct: a driver queues expected ask/result events,
// a negedge monitor pops and compares them; digests come from a reference model.
module tb_sha256_duct;

  logic inclk = 1'b0;
  logic reset = 1'b1;
  sha256_duct_if bus ();

  sha256_duct dut (.inclk(inclk), .reset(reset), .bus(bus));

  always #5 inclk = ~inclk;

  typedef struct {
    bit is_res;
    int cyc;
    bit val;
  } ev_t;

  ev_t  q[$];
  int   errors = 0;
  int   checks = 0;
  int   edge_cnt = 0;
  logic [511:0] blks [4];

  localparam logic [255:0] IV =
    256'h5be0cd19_1f83d9ab_9b05688c_510e527f_a54ff53a_3c6ef372_bb67ae85_6a09e667;
  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Reference compression: full 64-word expansion, digest packed {H7..H0}.
  function automatic logic [255:0] sha_block(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] wv [64];
    logic [31:0] v [8];
    logic [31:0] s0, s1, x1, x2;
    logic [255:0] out;
    for (int i = 0; i < 8; i++) v[i] = hin[32*i +: 32];
    for (int i = 0; i < 16; i++) wv[i] = blk[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = ror(wv[i-15], 7) ^ ror(wv[i-15], 18) ^ (wv[i-15] >> 3);
      s1 = ror(wv[i-2], 17) ^ ror(wv[i-2], 19) ^ (wv[i-2] >> 10);
      wv[i] = s1 + wv[i-7] + s0 + wv[i-16];
    end
    for (int i = 0; i < 64; i++) begin
      x1 = v[7] + (ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25))
           + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[i] + wv[i];
      x2 = (ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22))
           + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int j = 7; j > 0; j--) v[j] = v[j-1];
      v[4] = v[4] + x1;
      v[0] = x1 + x2;
    end
    for (int i = 0; i < 8; i++) out[32*i +: 32] = hin[32*i +: 32] + v[i];
    return out;
  endfunction

  function automatic logic [511:0] rand_block();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom();
    return r;
  endfunction

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge inclk or posedge reset) begin
    if (reset) edge_cnt <= 0;
    else       edge_cnt <= edge_cnt + 1;
  end

  // Monitor: pops expected events as the DUT presents ask pulses and results.
  bit prev_ask = 1'b0;
  bit in_done  = 1'b0;
  bit held     = 1'b0;
  always @(negedge inclk) begin
    ev_t ev;
    if (reset) begin
      prev_ask = 1'b0;
      in_done  = 1'b0;
    end else begin
      if (bus.ask) begin
        if (q.size() == 0 || q[0].is_res) begin
          check(1'b0, "ask_unexpected", 64'(edge_cnt), 64'(0));
        end else begin
          ev = q.pop_front();
          check(edge_cnt == ev.cyc, "ask_cycle", 64'(edge_cnt), 64'(ev.cyc));
        end
      end else if (prev_ask && q.size() > 0 && q[0].is_res) begin
        ev = q.pop_front();
        check(bus.result == ev.val, "result", 64'(bus.result), 64'(ev.val));
        check(edge_cnt == ev.cyc, "result_cycle", 64'(edge_cnt), 64'(ev.cyc));
        in_done = 1'b1;
        held    = ev.val;
      end else if (in_done) begin
        check(bus.result == held, "done_hold", 64'(bus.result), 64'(held));
      end else begin
        check(bus.result == 1'b0, "result_early", 64'(bus.result), 64'(0));
      end
      prev_ask = bus.ask;
    end
  end

  // Driver: resets, queues expectations, feeds blocks/digest on each ask.
  task automatic run_msg(input int m, input logic [255:0] dig, input bit exp_res,
                         input int hold_cycles, input int abort_after);
    bit ok;
    reset = 1'b1;
    q.delete();
    for (int j = 1; j <= m; j++) q.push_back('{is_res: 1'b0, cyc: 65*j, val: 1'b0});
    q.push_back('{is_res: 1'b1, cyc: 65*m + 1, val: exp_res});
    bus.block_n = blks[0];
    bus.readout = (m == 1);
    @(negedge inclk);
    #2 reset = 1'b0;
    if (abort_after > 0) begin
      repeat (abort_after) @(negedge inclk);
    end else begin
      ok = 1'b1;
      for (int j = 1; j <= m && ok; j++) begin
        ok = 1'b0;
        for (int k = 0; k < 100 && !ok; k++) begin
          @(negedge inclk);
          if (bus.ask) ok = 1'b1;
        end
        if (!ok) begin
          check(1'b0, "ask_timeout", 64'(edge_cnt), 64'(65*j));
        end else if (j < m) begin
          bus.block_n = blks[j];
          bus.readout = (j == m - 1);
        end else begin
          bus.block_n = {rand_block()[511:256], dig};
          bus.readout = 1'($urandom_range(0, 1));
        end
      end
      repeat (3) @(negedge inclk);
      for (int k = 0; k < hold_cycles; k++) begin
        bus.block_n = rand_block();
        bus.readout = 1'($urandom_range(0, 1));
        @(negedge inclk);
      end
      check(q.size() == 0, "events_left", 64'(q.size()), 64'(0));
    end
    @(negedge inclk);
    #2 reset = 1'b1;
    #1;
    check(bus.ask == 1'b0, "reset_ask", 64'(bus.ask), 64'(0));
    check(bus.result == 1'b0, "reset_result", 64'(bus.result), 64'(0));
    q.delete();
  endtask

  logic [255:0] abc_dig, two_dig, dig;
  initial begin
    int m;
    bit good;
    bus.block_n = '0;
    bus.readout = 1'b0;
    abc_dig = 256'hf20015ad_b410ff61_96177a9c_b00361a3_5dae2223_414140de_8f01cfea_ba7816bf;
    two_dig = 256'h19db06c1_f6ecedd4_64ff2167_a33ce459_0c3e6039_e5c02693_d20638b8_248d6a61;
    repeat (2) @(negedge inclk);

    blks[0] = {32'h61626380, 448'd0, 32'h00000018};
    run_msg(1, abc_dig, 1'b1, 200, 0);
    run_msg(1, abc_dig ^ 256'd1, 1'b0, 40, 0);

    blks[0] = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
               32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
               32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
               32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    blks[1] = {480'd0, 32'h000001c0};
    run_msg(2, two_dig, 1'b1, 10, 0);

    blks[0] = rand_block();
    run_msg(1, 256'd0, 1'b0, 0, 30);
    blks[0] = {32'h61626380, 448'd0, 32'h00000018};
    run_msg(1, abc_dig, 1'b1, 5, 0);

    for (int r = 0; r < 8; r++) begin
      m = $urandom_range(1, 3);
      dig = IV;
      for (int j = 0; j < m; j++) begin
        blks[j] = rand_block();
        dig = sha_block(dig, blks[j]);
      end
      good = 1'($urandom_range(0, 1));
      if (!good) dig[$urandom_range(0, 255)] ^= 1'b1;
      run_msg(m, dig, good, 5, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sha256_duct.md
Name: sha256_duct

Overview:
- Iterative SHA-256 compression engine that processes one 512-bit message block at a time and computes one round per clock.
- It chains the blocks of a pre-padded message, then checks the final digest against an expected digest supplied on the same data bus.
- It sits between a block source, which answers `ask` requests, and a pass/fail monitor, which consumes `result`.
- Message padding is done upstream.

Parameters:
- none. The number of blocks is set per message by the `readout` flag.

Ports:
- `inclk`  input  1  system clock; all state updates on rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `readout`  input  1  last-block flag, sampled together with `block_n`. 1 means the block being captured is the final block of the message.
- `block_n`  input  512  message block. Word W0 is at [511:480] and W15 at [31:0], big-endian. In the check phase, [255:0] holds the expected digest: H0 at [31:0] through H7 at [255:224]. Bits [511:256] are ignored in the check phase.
- `result`  output  1  digest-match flag, registered.
- `ask`  output  1  request for the next `block_n`, registered.

Behaviour:
- Reset (asynchronous, while `reset`=1):
  - H0..H7 are set to the standard SHA-256 IV (6a09e667 … 5be0cd19).
  - State is LOAD, `last`=0, `ask`=0, `result`=0.
  - Reset mid-operation aborts the current message with no partial output.
- LOAD state:
  - At the first rising edge after reset release, capture `block_n` into the 16-word schedule window and latch `last` from `readout`.
  - Set a..h from H0..H7, round counter t=0, then go to ROUND.
  - `ask` stays 0 in this state.
- ROUND state (64 edges, t=0..63):
  - Standard SHA-256 round: T1 = h+Σ1(e)+Ch(e,f,g)+K[t]+W[t]; T2 = Σ0(a)+Maj(a,b,c).
  - W[t] for t≥16 comes from a rolling 16-word window: σ1(W[t-2])+W[t-7]+σ0(W[t-15])+W[t-16].
  - All additions are mod 2^32. K is a 64-entry constant ROM.
  - On the t=63 edge, H[i] <= H[i] + updated working variable, mod 2^32. On the same edge `ask` <= 1 and the state goes to ASK.
  - Block capture to `ask` high is 64 edges.
- ASK state (exactly one cycle, `ask`=1):
  - The source drives the next `block_n` and `readout` before the next rising edge.
  - At that edge `ask` <= 0.
  - If `last`=0: capture the new block, latch `last` from `readout`, load a..h from H, and go to ROUND. The next block's capture edge is 65 edges after the previous capture.
  - If `last`=1: set `result` <= (`block_n`[255:0] == {H7,…,H0}), then go to DONE.
- DONE state:
  - `result` holds and `ask` stays 0.
  - Inputs are ignored until reset.
  - A new message requires a reset.
- `ask` is a single-cycle pulse per completed block. There are never two consecutive `ask` cycles.
- `readout` is sampled only on capture edges. Its value at other times is don't-care.
- Throughput: one block per 65 cycles. An M-block message yields `result` at edge 65·M+1 after reset release.

Test Plan:
- Reset:
  - Stimulus: assert `reset` mid-ROUND.
  - Required: `ask`=0 and `result`=0 immediately, with no clock edge needed. After release, the first edge captures a fresh block using the IV.
- Single block "abc" (M=1):
  - Stimulus: `block_n`=61626380 00…00 00000018 with `readout`=1 at the first capture. On `ask`, drive the expected digest; from [255:224] down to [31:0]: f20015ad b410ff61 96177a9c b00361a3 5dae2223 414140de 8f01cfea ba7816bf.
  - Required: `ask` high exactly one cycle after 64 edges; `result`=1 at edge 66.
- Two blocks "abcdbcde…nopq" (M=2):
  - Stimulus: block0 = 61626364 62636465 … 6e6f7071 80000000 00000000 with `readout`=0. On the first `ask`, drive block1 (zeros, length 000001c0) with `readout`=1. On the second `ask`, drive the expected digest 19db06c1 f6ecedd4 64ff2167 a33ce459 0c3e6039 e5c02693 d20638b8 248d6a61.
  - Required: `ask` pulses at cycles 65 and 130; `result`=1 at edge 131.
- Mismatch:
  - Stimulus: same as the "abc" case, with bit 0 of the expected digest flipped.
  - Required: `result`=0 and DONE is reached; `ask` never re-asserts.
- DONE hold:
  - Stimulus: after `result` is set, toggle `block_n` and `readout` for 200 cycles.
  - Required: `result` and `ask` stay unchanged.
